// File: rtl/uart_wb_bridge_pkg.sv
// Shared command/response codes, FSM state type and byte-assembly helper
// for the UART-to-Wishbone debug bridge.
package uart_wb_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RSP_OK    = 8'hAA;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

  // Frames arrive MSB first: each new byte lands in the low byte.
  function automatic logic [31:0] shift_in(input logic [31:0] acc, input logic [7:0] b);
    return {acc[23:0], b};
  endfunction

endpackage

// File: rtl/uart_wb_bridge_if.sv
// UART byte handshake and Wishbone master signals of the debug bridge,
// with the bridge-side and environment-side views.
interface uart_wb_bridge_if;

  logic [7:0]  rx_data;
  logic        rx_avail;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_dat_w;
  logic [31:0] dbg_dat_r;
  logic [3:0]  dbg_sel;
  logic        dbg_we;
  logic        dbg_cyc;
  logic        dbg_stb;
  logic        dbg_ack;

  modport bridge (
    input  rx_data, rx_avail, tx_busy, dbg_dat_r, dbg_ack,
    output rx_ack, tx_data, tx_wr, dbg_adr, dbg_dat_w, dbg_sel, dbg_we, dbg_cyc, dbg_stb
  );

  modport host (
    output rx_data, rx_avail, tx_busy, dbg_dat_r, dbg_ack,
    input  rx_ack, tx_data, tx_wr, dbg_adr, dbg_dat_w, dbg_sel, dbg_we, dbg_cyc, dbg_stb
  );

endinterface

// File: rtl/uart_wb_bridge_txser.sv
// Response serializer: loads 1 or 4 bytes (left-aligned) and emits them MSB
// first on tx_wr/tx_data, honouring tx_busy.
module uart_wb_bridge_txser (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_cnt,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_wr,
  output logic        o_done
);

  logic [31:0] r_buf;
  logic [2:0]  r_left;
  logic        r_tx_wr;
  logic        r_guard;
  logic        r_done;
  logic [7:0]  r_tx_data;
  logic        w_send;

  // The uart raises tx_busy one cycle late, so the strobe cycle and the one
  // after it are blocked regardless of what tx_busy says.
  assign w_send = (r_left != 3'd0) && !r_tx_wr && !r_guard && !i_tx_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf     <= 32'h0;
      r_left    <= 3'd0;
      r_tx_wr   <= 1'b0;
      r_guard   <= 1'b0;
      r_done    <= 1'b0;
      r_tx_data <= 8'h0;
    end else begin
      r_tx_wr <= 1'b0;
      r_done  <= 1'b0;
      r_guard <= r_tx_wr;
      if (i_load) begin
        r_buf  <= i_data;
        r_left <= i_cnt;
      end else if (w_send) begin
        r_tx_wr   <= 1'b1;
        r_tx_data <= r_buf[31:24];
        r_buf     <= {r_buf[23:0], 8'h00};
        r_left    <= r_left - 3'd1;
        r_done    <= (r_left == 3'd1);
      end
    end
  end

  assign o_tx_data = r_tx_data;
  assign o_tx_wr   = r_tx_wr;
  assign o_done    = r_done;

endmodule

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone debug bridge: parses read/write command frames from the
// uart byte stream, runs one Wishbone access and returns a response.
module uart_wb_bridge
  import uart_wb_bridge_pkg::*;
#(
  parameter int wb_timeout = 1024,
  parameter int rx_timeout = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_wb_bridge_if.bridge  bus
);

  localparam int WBW = $clog2(wb_timeout + 1);
  localparam int RXW = $clog2(rx_timeout + 1);
  localparam logic [WBW-1:0] WB_LIM = WBW'(wb_timeout - 1);
  localparam logic [RXW-1:0] RX_LIM = RXW'(rx_timeout - 1);

  state_t          r_state;
  logic [1:0]      r_cnt;
  logic            r_we;
  logic [31:0]     r_adr;
  logic [31:0]     r_dat;
  logic [WBW-1:0]  r_wb_cnt;
  logic [RXW-1:0]  r_rx_cnt;
  logic            r_rx_ack;
  logic [31:0]     r_dbg_adr;
  logic [31:0]     r_dbg_dat_w;
  logic [3:0]      r_dbg_sel;
  logic            r_dbg_we;
  logic            r_dbg_cyc;
  logic            r_dbg_stb;

  logic            w_byte_ok;
  logic            w_ack_hit;
  logic            w_wb_expire;
  logic            w_tx_load;
  logic [31:0]     w_tx_bytes;
  logic [2:0]      w_tx_cnt;
  logic            w_tx_done;
  logic [7:0]      w_tx_data;
  logic            w_tx_wr;

  // A byte is taken only while parsing, and never in the cycle rx_ack is up.
  assign w_byte_ok   = (r_state inside {ST_IDLE, ST_ADDR, ST_DATA}) && bus.rx_avail && !r_rx_ack;
  assign w_ack_hit   = r_dbg_cyc && bus.dbg_ack;
  assign w_wb_expire = r_dbg_cyc && (r_wb_cnt == WB_LIM);
  assign w_tx_load   = (r_state == ST_BUS) && (w_ack_hit || w_wb_expire);

  // Ack wins over a simultaneous timeout expiry.
  always_comb begin
    w_tx_bytes = {RSP_ERR, 24'h0};
    w_tx_cnt   = 3'd1;
    if (w_ack_hit) begin
      if (r_dbg_we) begin
        w_tx_bytes = {RSP_OK, 24'h0};
      end else begin
        w_tx_bytes = bus.dbg_dat_r;
        w_tx_cnt   = 3'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_we        <= 1'b0;
      r_adr       <= 32'h0;
      r_dat       <= 32'h0;
      r_wb_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_rx_ack    <= 1'b0;
      r_dbg_adr   <= 32'h0;
      r_dbg_dat_w <= 32'h0;
      r_dbg_sel   <= 4'h0;
      r_dbg_we    <= 1'b0;
      r_dbg_cyc   <= 1'b0;
      r_dbg_stb   <= 1'b0;
    end else begin
      r_rx_ack <= w_byte_ok;
      case (r_state)
        ST_IDLE: begin
          if (w_byte_ok && (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ)) begin
            r_we     <= (bus.rx_data == CMD_WRITE);
            r_cnt    <= 2'd0;
            r_rx_cnt <= '0;
            r_state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_byte_ok) begin
            r_adr    <= shift_in(r_adr, bus.rx_data);
            r_cnt    <= r_cnt + 2'd1;
            r_rx_cnt <= '0;
            if (r_cnt == 2'd3) r_state <= r_we ? ST_DATA : ST_BUS;
          end else if (r_rx_cnt == RX_LIM) begin
            r_state <= ST_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + RXW'(1);
          end
        end
        ST_DATA: begin
          if (w_byte_ok) begin
            r_dat    <= shift_in(r_dat, bus.rx_data);
            r_cnt    <= r_cnt + 2'd1;
            r_rx_cnt <= '0;
            if (r_cnt == 2'd3) r_state <= ST_BUS;
          end else if (r_rx_cnt == RX_LIM) begin
            r_state <= ST_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + RXW'(1);
          end
        end
        ST_BUS: begin
          // First BUS cycle launches the access; cyc low here only then.
          if (!r_dbg_cyc) begin
            r_dbg_cyc   <= 1'b1;
            r_dbg_stb   <= 1'b1;
            r_dbg_sel   <= 4'hF;
            r_dbg_we    <= r_we;
            r_dbg_adr   <= r_adr;
            r_dbg_dat_w <= r_we ? r_dat : 32'h0;
            r_wb_cnt    <= '0;
          end else if (w_ack_hit || w_wb_expire) begin
            r_dbg_cyc   <= 1'b0;
            r_dbg_stb   <= 1'b0;
            r_dbg_sel   <= 4'h0;
            r_dbg_we    <= 1'b0;
            r_dbg_adr   <= 32'h0;
            r_dbg_dat_w <= 32'h0;
            r_state     <= ST_RESP;
          end else begin
            r_wb_cnt <= r_wb_cnt + WBW'(1);
          end
        end
        ST_RESP: begin
          if (w_tx_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_wb_bridge_txser u_txser (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_load    (w_tx_load),
    .i_data    (w_tx_bytes),
    .i_cnt     (w_tx_cnt),
    .i_tx_busy (bus.tx_busy),
    .o_tx_data (w_tx_data),
    .o_tx_wr   (w_tx_wr),
    .o_done    (w_tx_done)
  );

  assign bus.rx_ack    = r_rx_ack;
  assign bus.tx_data   = w_tx_data;
  assign bus.tx_wr     = w_tx_wr;
  assign bus.dbg_adr   = r_dbg_adr;
  assign bus.dbg_dat_w = r_dbg_dat_w;
  assign bus.dbg_sel   = r_dbg_sel;
  assign bus.dbg_we    = r_dbg_we;
  assign bus.dbg_cyc   = r_dbg_cyc;
  assign bus.dbg_stb   = r_dbg_stb;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: uart byte driver, busy-modelling tx
// monitor and a Wishbone slave with programmable ack delay.
module tb_uart_wb_bridge;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } bus_t;

  logic clk;
  logic reset_n;
  uart_wb_bridge_if bus_if ();

  uart_wb_bridge #(.wb_timeout(1024), .rx_timeout(200)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  tx_q[$];
  bus_t        bus_q[$];
  int          ack_delay = 3;
  bit          no_ack = 1'b0;
  logic [31:0] rd_data = 32'h0;
  int          cyc_no = 0;
  int          ack_cyc = 0;
  int          ack_seq = 0;
  int          seen_seq = 0;
  int          stb_cyc = 0;
  int          last_stb_len = 0;
  int          busy_cnt = 0;
  bit          busy_arm = 1'b0;
  logic        prev_wr = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_no++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  // Wishbone slave: acks on the ack_delay-th strobe cycle unless no_ack.
  always @(negedge clk) begin
    if (!reset_n) begin
      bus_if.dbg_ack   = 1'b0;
      bus_if.dbg_dat_r = 32'h0;
      if (stb_cyc != 0) last_stb_len = stb_cyc;
      stb_cyc = 0;
    end else if (bus_if.dbg_ack === 1'b1) begin
      bus_if.dbg_ack = 1'b0;
      chk("cyc_after_ack", {31'h0, bus_if.dbg_cyc}, 32'h0);
      chk("stb_after_ack", {31'h0, bus_if.dbg_stb}, 32'h0);
      stb_cyc = 0;
    end else if (bus_if.dbg_cyc === 1'b1 && bus_if.dbg_stb === 1'b1) begin
      stb_cyc++;
      if (!no_ack && stb_cyc == ack_delay) begin
        bus_if.dbg_ack   = 1'b1;
        bus_if.dbg_dat_r = rd_data;
        ack_cyc = cyc_no;
        ack_seq++;
        if (bus_q.size() == 0) begin
          chk("bus_unexp", bus_q.size(), 32'd1);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_adr", bus_if.dbg_adr, e.adr);
          chk("bus_we", {31'h0, bus_if.dbg_we}, {31'h0, e.we});
          chk("bus_sel", {28'h0, bus_if.dbg_sel}, 32'hF);
          if (e.we) chk("bus_dat_w", bus_if.dbg_dat_w, e.dat);
        end
      end
    end else begin
      if (stb_cyc != 0) last_stb_len = stb_cyc;
      stb_cyc = 0;
    end
  end

  // uart transmitter model: busy appears a cycle after tx_wr and lasts a while.
  always @(negedge clk) begin
    logic b_prev;
    b_prev = bus_if.tx_busy;
    if (!reset_n) begin
      busy_cnt = 0;
      busy_arm = 1'b0;
      prev_wr  = 1'b0;
      bus_if.tx_busy = 1'b0;
    end else begin
      if (busy_arm) begin
        busy_cnt = 6;
        busy_arm = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (bus_if.tx_wr === 1'b1) begin
        chk("tx_wr_pulse", {31'h0, prev_wr}, 32'h0);
        chk("tx_busy_respect", {31'h0, b_prev}, 32'h0);
        if (seen_seq != ack_seq) begin
          chk("tx_latency_le2", ((cyc_no - ack_cyc) <= 2) ? 32'd1 : 32'd0, 32'd1);
          seen_seq = ack_seq;
        end
        if (tx_q.size() == 0) chk("tx_unexp", {24'h0, bus_if.tx_data}, 32'h100);
        else chk("tx_byte", {24'h0, bus_if.tx_data}, {24'h0, tx_q.pop_front()});
        busy_arm = 1'b1;
      end
      prev_wr = bus_if.tx_wr;
      bus_if.tx_busy = (busy_cnt > 0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus_if.rx_data  = b;
    bus_if.rx_avail = 1'b1;
    while (bus_if.rx_ack !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rx_ack_seen", {31'h0, bus_if.rx_ack}, 32'h1);
    bus_if.rx_avail = 1'b0;
    @(posedge clk);
    #1;
    chk("rx_ack_pulse", {31'h0, bus_if.rx_ack}, 32'h0);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] adr,
                            input logic [31:0] dat, input bit with_data);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
    if (with_data) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
  endtask

  task automatic expect_write(input logic [31:0] adr, input logic [31:0] dat);
    bus_q.push_back('{adr: adr, we: 1'b1, dat: dat});
    tx_q.push_back(8'hAA);
  endtask

  task automatic expect_read(input logic [31:0] adr, input logic [31:0] dat);
    bus_q.push_back('{adr: adr, we: 1'b0, dat: 32'h0});
    for (int i = 3; i >= 0; i--) tx_q.push_back(dat[i*8 +: 8]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((tx_q.size() != 0 || bus_q.size() != 0) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk("tx_drained", tx_q.size(), 32'd0);
    chk("bus_drained", bus_q.size(), 32'd0);
    repeat (10) @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_rx_ack"}, {31'h0, bus_if.rx_ack}, 32'h0);
    chk({pfx, "_tx_wr"}, {31'h0, bus_if.tx_wr}, 32'h0);
    chk({pfx, "_tx_data"}, {24'h0, bus_if.tx_data}, 32'h0);
    chk({pfx, "_dbg_adr"}, bus_if.dbg_adr, 32'h0);
    chk({pfx, "_dbg_dat_w"}, bus_if.dbg_dat_w, 32'h0);
    chk({pfx, "_dbg_sel"}, {28'h0, bus_if.dbg_sel}, 32'h0);
    chk({pfx, "_dbg_we"}, {31'h0, bus_if.dbg_we}, 32'h0);
    chk({pfx, "_dbg_cyc"}, {31'h0, bus_if.dbg_cyc}, 32'h0);
    chk({pfx, "_dbg_stb"}, {31'h0, bus_if.dbg_stb}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus_if.rx_data  = 8'h0;
    bus_if.rx_avail = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Write, slave acks on the third strobe cycle.
    expect_write(32'h0000_1000, 32'hDEAD_BEEF);
    send_frame(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
    wait_drain();

    // Read followed back-to-back by a write held pending during BUS/RESP.
    rd_data = 32'h1234_5678;
    expect_read(32'h0000_1000, 32'h1234_5678);
    expect_write(32'h0000_2000, 32'h0102_0304);
    send_frame(8'h02, 32'h0000_1000, 32'h0, 1'b0);
    send_frame(8'h01, 32'h0000_2000, 32'h0102_0304, 1'b1);
    wait_drain();

    // Unmapped read: no ack, abort after the bus timeout.
    no_ack = 1'b1;
    tx_q.push_back(8'hEE);
    send_frame(8'h02, 32'hF000_0000, 32'h0, 1'b0);
    wait_drain();
    chk("wb_timeout_len", last_stb_len, 32'd1024);
    no_ack = 1'b0;

    // Unknown command byte is swallowed, then a normal read.
    ack_delay = 1;
    rd_data = 32'hCAFE_F00D;
    expect_read(32'h0000_0020, 32'hCAFE_F00D);
    send_byte(8'h55);
    send_frame(8'h02, 32'h0000_0020, 32'h0, 1'b0);
    wait_drain();

    // Partial write abandoned by the inter-byte timeout, then a read.
    ack_delay = 5;
    rd_data = 32'h0BAD_F00D;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (260) @(posedge clk);
    expect_read(32'h0000_0044, 32'h0BAD_F00D);
    send_frame(8'h02, 32'h0000_0044, 32'h0, 1'b0);
    wait_drain();

    // Reset while the bus access is outstanding.
    no_ack = 1'b1;
    send_frame(8'h02, 32'h0000_0080, 32'h0, 1'b0);
    begin
      int n = 0;
      while (bus_if.dbg_stb !== 1'b1 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("stb_before_rst", {31'h0, bus_if.dbg_stb}, 32'h1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    no_ack = 1'b0;
    ack_delay = 2;
    rd_data = 32'hA5A5_5A5A;
    expect_read(32'h0000_0084, 32'hA5A5_5A5A);
    send_frame(8'h02, 32'h0000_0084, 32'h0, 1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
